// File: rtl/board_debug_ctrl.sv
// CPU clock generator (free-run / manual step / burst / halt) with key debouncing,
// plus the debug-channel selector that feeds the 7-segment digit decoders.
module board_debug_ctrl #(
  parameter int NCH        = 4,
  parameter int DW         = 32,
  parameter int NDIG       = 6,
  parameter int DIV_W      = 4,
  parameter int DEB_CYCLES = 16,
  parameter int HB_W       = 24,
  localparam int SEL_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  divisor,
  input  logic              step_key_n,
  input  logic [7:0]        burst_len,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic              freeze,
  input  logic              blank_lz,
  output logic              clock_cpu,
  output logic              cpu_rise,
  output logic              busy,
  output logic [31:0]       cycle_count,
  output logic [NDIG*4-1:0] hex_nibbles,
  output logic [NDIG-1:0]   hex_blank,
  output logic              heartbeat
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_STEP} state_t;

  logic [DIV_W-1:0] div_cnt, div_lat;
  logic             tick;
  logic             key_s1, key_s2, key_acc, press;
  logic [DEB_W-1:0] deb_cnt;
  state_t           state, state_nx;
  logic             clk_nx, rise_nx;
  logic [7:0]       rem, rem_nx;
  logic [HB_W-1:0]  hb_cnt;
  logic [DW-1:0]    sel_val;
  logic [NDIG*4-1:0] nib_nx;
  logic [NDIG-1:0]  blank_nx;
  logic             upper_zero;
  logic             unused_hi;

  // Divisor is latched only at the wrap so a change never truncates a phase.
  assign tick = (div_cnt == div_lat);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      div_lat <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      div_lat <= divisor;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      key_s1  <= 1'b1;
      key_s2  <= 1'b1;
      key_acc <= 1'b1;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      key_s1 <= step_key_n;
      key_s2 <= key_s1;
      press  <= 1'b0;
      if (key_s2 == key_acc) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb_cnt <= '0;
        key_acc <= key_s2;
        press   <= ~key_s2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= ST_STOP;
      clock_cpu <= 1'b0;
      rem       <= '0;
    end else begin
      state     <= state_nx;
      clock_cpu <= clk_nx;
      rem       <= rem_nx;
    end
  end

  // A high phase is always allowed to finish; stopping only happens while low.
  always_comb begin
    state_nx = state;
    clk_nx   = clock_cpu;
    rem_nx   = rem;
    case (state)
      ST_STOP: begin
        clk_nx = 1'b0;
        if (mode == 2'b00) begin
          state_nx = ST_RUN;
        end else if (press && mode == 2'b01) begin
          state_nx = ST_STEP;
          rem_nx   = 8'd1;
        end else if (press && mode == 2'b10 && burst_len != 8'd0) begin
          state_nx = ST_STEP;
          rem_nx   = burst_len;
        end
      end
      ST_RUN: begin
        if (clock_cpu) begin
          if (tick) begin
            clk_nx = 1'b0;
            if (mode != 2'b00) state_nx = ST_STOP;
          end
        end else if (mode != 2'b00) begin
          state_nx = ST_STOP;
        end else if (tick) begin
          clk_nx = 1'b1;
        end
      end
      ST_STEP: begin
        if (clock_cpu) begin
          if (tick) begin
            clk_nx = 1'b0;
            rem_nx = rem - 8'd1;
            if (rem == 8'd1 || mode == 2'b11) state_nx = ST_STOP;
          end
        end else if (mode == 2'b11) begin
          state_nx = ST_STOP;
        end else if (tick) begin
          clk_nx = 1'b1;
        end
      end
      default: begin
        state_nx = ST_STOP;
        clk_nx   = 1'b0;
      end
    endcase
  end

  always_comb begin
    busy    = (state == ST_STEP);
    rise_nx = clk_nx & ~clock_cpu;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      cpu_rise    <= 1'b0;
      cycle_count <= '0;
    end else begin
      cpu_rise <= rise_nx;
      if (rise_nx) cycle_count <= cycle_count + 32'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
      if (&hb_cnt) heartbeat <= ~heartbeat;
    end
  end

  // Out-of-range selects fall through to zero; blanking scans from the top digit down.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(ch_sel) == i) sel_val = ch_data[i*DW +: DW];
    end
    nib_nx     = sel_val[NDIG*4-1:0];
    blank_nx   = '0;
    upper_zero = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      upper_zero  = upper_zero & (nib_nx[i*4 +: 4] == 4'd0);
      blank_nx[i] = blank_lz & upper_zero;
    end
  end

  assign unused_hi = ^(sel_val >> (NDIG * 4));

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      hex_nibbles <= '0;
      hex_blank   <= ~NDIG'(1);
    end else if (!freeze) begin
      hex_nibbles <= nib_nx;
      hex_blank   <= blank_nx;
    end
  end

endmodule

// File: doc/board_debug_ctrl.md
Name: board_debug_ctrl

Overview:
Board-level debug/clock controller for the FPGA top: generates the CPU clock from CLOCK_50 with free-run, manual-step, burst-step and halt modes, and selects one of NCH 32-bit debug channels (PC, instruction, register, ...) for the 7-segment digits with leading-zero blanking. Replaces the ad-hoc divider/key/mux logic in the top. The decoder7 instances sit downstream of hex_nibbles/hex_blank.

Parameters:
NCH, 4, number of debug channels
DW, 32, channel width
NDIG, 6, displayed hex digits (NDIG*4 <= DW)
DIV_W, 4, divisor width
DEB_CYCLES, 16, cycles a key must be stable to be accepted
HB_W, 24, heartbeat counter width

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low
mode  in  2  00 free-run, 01 manual, 10 burst, 11 halt
divisor  in  DIV_W  tick every divisor+1 CLOCK_50 cycles
step_key_n  in  1  raw step key, active-low, asynchronous
burst_len  in  8  CPU cycles per burst press
ch_data  in  NCH*DW  flattened channels, channel i at [i*DW +: DW]
ch_sel  in  $clog2(NCH)  displayed channel
freeze  in  1  hold displayed value
blank_lz  in  1  enable leading-zero blanking
clock_cpu  out  1  generated CPU clock
cpu_rise  out  1  one-cycle pulse coincident with clock_cpu rising
busy  out  1  step/burst in progress
cycle_count  out  32  clock_cpu rising edges since reset, wraps
hex_nibbles  out  NDIG*4  digit i at [i*4 +: 4]
hex_blank  out  NDIG  1 = digit i dark
heartbeat  out  1  toggles every 2^HB_W cycles

Behaviour:
- Reset (reset=0, async): clock_cpu=0, cpu_rise=0, busy=0, cycle_count=0, hex_nibbles=0, hex_blank = all 1 except bit0=0, heartbeat=0, FSM STOP, debouncer in released state.
- Tick: counter 0..divisor, tick asserted when counter==divisor, then clears; divisor=0 → tick every cycle. clock_cpu changes only on tick; period = 2*(divisor+1) cycles. A divisor change takes effect at the next counter wrap.
- Key: 2-FF synchroniser, then debouncer; state accepted after DEB_CYCLES consecutive equal samples. press = one-cycle pulse on accepted released→pressed. Latency raw→press = 2+DEB_CYCLES cycles.
- FSM states STOP, RUN, STEP (remaining counter rem, 8 bits):
  STOP: mode 00 → RUN; mode 01 with press → STEP, rem=1; mode 10 with press and burst_len!=0 → STEP, rem=burst_len; burst_len=0 → ignored; mode 11 → stay.
  RUN: clock_cpu toggles on every tick; on mode!=00, finish the current high phase, go STOP with clock_cpu=0.
  STEP: busy=1; toggles on ticks; each falling edge decrements rem; at rem reaching 0 → STOP. mode 11 aborts after current high phase completes. Presses during STEP ignored (no queueing).
- clock_cpu never produces a high phase shorter than divisor+1 cycles; always stops low.
- cpu_rise=1 in the cycle clock_cpu goes 0→1; cycle_count increments same cycle, wraps 2^32-1→0.
- Display: value register loads ch_data[ch_sel] every cycle unless freeze=1 (1-cycle latency); ch_sel>=NCH selects 0. hex_nibbles = low NDIG*4 bits of value register.
- blank_lz=1: digit i blanked iff all digits i..NDIG-1 are 0 and i>0; digit 0 never blank. blank_lz=0: hex_blank=0. Registered with value (same latency).
- heartbeat: free-running HB_W-bit counter, toggles on wrap.

Test Plan:
- Free run: divisor=3, mode=00 → clock_cpu period 8 cycles, 50% duty; after 10 rises cycle_count=10, cpu_rise 10 single-cycle pulses.
- Manual with bounce: mode=01, step_key_n chattering 5 cycles then held low 40 cycles (DEB_CYCLES=16) → exactly one clock_cpu pulse, busy high only during it, cycle_count +1.
- Burst: mode=10, burst_len=5, divisor=0, one press → exactly 5 rises, busy deasserts after 5th falling edge; second press during burst ignored; burst_len=0 → no pulses.
- Mode change mid-high: RUN, divisor=7, switch to 11 two cycles after rise → clock_cpu stays high full 8 cycles, then low forever; no further rises.
- Display: ch_data ch2=0x0000_0A05, ch_sel=2, blank_lz=1 → hex_nibbles=0x000A05, hex_blank=6'b111000; value 0 → 6'b111110; freeze=1 then change ch_data → outputs hold.
- Async reset mid-burst (rem=3, clock_cpu=1) → all outputs at reset values immediately, no pulses after reset release until new press.
